// File: rtl/line_serializer.sv
`timescale 1ns/1ps
// line_serializer
// Reads whole lines from a wide line RAM and streams each line out as a
// sequence of WORD_W-bit words with valid/ready handshaking. A command
// (start) names a first line address, an address stride and a line count.
// Word 0 of a line is the most-significant WORD_W bits of line_in.
//
// Ports:
//   clk, reset_n          clock (rising edge) and async active-low reset
//   start                 one-cycle command strobe, honoured only when idle
//   base_addr, stride     first line address / per-line increment (mod 2^ADDR_W)
//   num_lines             lines to stream; 0 completes at once with no reads
//   rd_req, rd_addr       line RAM read request and address
//   line_in               line RAM data, valid the cycle after rd_req
//   out_valid, out_ready  output word handshake
//   out_data              current output word
//   out_last_word         current word is the last word of its line
//   out_last_line         current word belongs to the last line of the command
//   busy                  command in progress
//   done                  one-cycle completion pulse
module line_serializer #(
  parameter int WORDS  = 32,
  parameter int WORD_W = 64,
  parameter int ADDR_W = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [ADDR_W-1:0]       stride,
  input  logic [7:0]              num_lines,
  output logic                    rd_req,
  output logic [ADDR_W-1:0]       rd_addr,
  input  logic [WORDS*WORD_W-1:0] line_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WORD_W-1:0]       out_data,
  output logic                    out_last_word,
  output logic                    out_last_line,
  output logic                    busy,
  output logic                    done
);

  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, SHIFT, DONE} state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] line_addr;
  logic [ADDR_W-1:0] line_stride;
  logic [7:0]        lines_total;
  logic [7:0]        line_idx;
  logic [IDX_W-1:0]  word_idx;
  logic [WORD_W-1:0] line_buf [WORDS];
  logic              last_word;
  logic              last_line;

  // lines_total is never 0 while a line is being shifted, so the
  // subtraction cannot underflow where last_line matters.
  assign last_word = (word_idx == IDX_W'(WORDS - 1));
  assign last_line = (line_idx == lines_total - 8'd1);

  // State register; reset drops straight back to IDLE, aborting any command.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and outputs. Every output is decoded from registers only,
  // so all of them read zero as soon as reset clears the registers.
  always_comb begin
    state_next    = state;
    rd_req        = 1'b0;
    rd_addr       = line_addr;
    out_valid     = 1'b0;
    out_data      = '0;
    out_last_word = 1'b0;
    out_last_line = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;

    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next = (num_lines != 8'd0) ? REQ : DONE;
        end
      end
      REQ: begin
        rd_req     = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        state_next = SHIFT;
      end
      SHIFT: begin
        out_valid     = 1'b1;
        out_data      = line_buf[word_idx];
        out_last_word = last_word;
        out_last_line = last_line;
        if (out_ready && last_word) begin
          state_next = last_line ? DONE : REQ;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: command latch, line capture and word/line counters.
  // The word index only advances on a handshake, which is what keeps the
  // output word steady during a stall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line_addr   <= '0;
      line_stride <= '0;
      lines_total <= '0;
      line_idx    <= '0;
      word_idx    <= '0;
      for (int k = 0; k < WORDS; k++) begin
        line_buf[k] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start && (num_lines != 8'd0)) begin
            line_addr   <= base_addr;
            line_stride <= stride;
            lines_total <= num_lines;
            line_idx    <= '0;
          end
        end
        WAIT: begin
          // Word 0 sits in the top WORD_W bits of the RAM line.
          for (int k = 0; k < WORDS; k++) begin
            line_buf[k] <= line_in[(WORDS-k)*WORD_W-1 -: WORD_W];
          end
          word_idx <= '0;
        end
        SHIFT: begin
          if (out_ready) begin
            if (last_word) begin
              if (!last_line) begin
                line_addr <= line_addr + line_stride;
                line_idx  <= line_idx + 8'd1;
              end
            end else begin
              word_idx <= word_idx + IDX_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
